// File: rtl/accumulator_alu_if.sv
// Bus/control bundle between the SAP-1 controller/datapath and the accumulator+ALU block.
// The slave modport is the accumulator side; master is the driving side (controller or bench).
interface accumulator_alu_if #(
    parameter int WIDTH = 8
);
    logic             loada;
    logic             enable;
    logic             su;
    logic             eu;
    logic [WIDTH-1:0] data_in_bus;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] data_out_bus;
    logic             bus_drive;
    logic [WIDTH-1:0] acc_out;
    logic             carry_flag;
    logic             zero_flag;
    logic             bus_conflict;

    modport master (
        output loada, enable, su, eu, data_in_bus, b_in,
        input  data_out_bus, bus_drive, acc_out, carry_flag, zero_flag, bus_conflict
    );

    modport slave (
        input  loada, enable, su, eu, data_in_bus, b_in,
        output data_out_bus, bus_drive, acc_out, carry_flag, zero_flag, bus_conflict
    );
endinterface

// File: rtl/accumulator_alu.sv
// SAP-1 accumulator (register A) merged with the add/subtract stage, driving the shared bus.
// Holds registered carry/zero flags and a sticky bus-conflict error bit.
module accumulator_alu #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    accumulator_alu_if.slave   bus
);
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             conflict_q, conflict_d;

    logic [WIDTH-1:0] b_op_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_carry_s;
    logic [WIDTH-1:0] data_out_s;

    // ALU: subtraction is A + ~B + 1, so carry=1 means no borrow
    always_comb begin
        b_op_s      = bus.su ? ~bus.b_in : bus.b_in;
        sum_s       = {1'b0, acc_q} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, bus.su};
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
    end

    // Bus output mux: ALU result has priority over the accumulator
    always_comb begin
        data_out_s = {WIDTH{1'b0}};
        if (bus.eu) begin
            data_out_s = alu_res_s;
        end else if (bus.enable) begin
            data_out_s = acc_q;
        end else begin
            data_out_s = {WIDTH{1'b0}};
        end
    end

    // Next-state logic for accumulator, flags and sticky conflict bit
    always_comb begin
        acc_d      = acc_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        conflict_d = conflict_q;
        if (bus.loada) begin
            acc_d = bus.data_in_bus;
        end else begin
            acc_d = acc_q;
        end
        if (bus.eu) begin
            carry_d = alu_carry_s;
            zero_d  = (alu_res_s == {WIDTH{1'b0}});
        end else begin
            carry_d = carry_q;
            zero_d  = zero_q;
        end
        if (bus.enable && bus.eu) begin
            conflict_d = 1'b1;
        end else begin
            conflict_d = conflict_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= {WIDTH{1'b0}};
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.data_out_bus = data_out_s;
    assign bus.bus_drive    = bus.enable | bus.eu;
    assign bus.acc_out      = acc_q;
    assign bus.carry_flag   = carry_q;
    assign bus.zero_flag    = zero_q;
    assign bus.bus_conflict = conflict_q;
endmodule

// File: tb/tb_accumulator_alu.sv
// Self-checking bench for accumulator_alu: scenario tasks with a scoreboard queue of ALU results.
module tb_accumulator_alu;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    logic [W-1:0] acc_m;

    always #5 clk = ~clk;

    accumulator_alu_if #(.WIDTH(W)) bus_if ();
    accumulator_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        int unsigned t;
        if (!s) begin
            t       = int'(a) + int'(b);
            e.res   = t[W-1:0];
            e.carry = (t > 255);
        end else begin
            e.res   = a - b;
            e.carry = (a >= b);
        end
        e.zero = (e.res == 8'h00);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.loada = 1'b0; bus_if.enable = 1'b0; bus_if.su = 1'b0; bus_if.eu = 1'b0;
        bus_if.data_in_bus = 8'h00; bus_if.b_in = 8'h00;
    endtask

    task automatic load(input logic [W-1:0] v);
        bus_if.loada = 1'b1; bus_if.data_in_bus = v;
        tick();
        bus_if.loada = 1'b0;
        acc_m = v;
    endtask

    // Drive an ALU operation and record its expected result from the bench model
    task automatic start_op(input logic [W-1:0] b, input logic s, input logic en);
        bus_if.b_in = b; bus_if.su = s; bus_if.eu = 1'b1; bus_if.enable = en;
        exp_q.push_back(model(acc_m, b, s));
    endtask

    task automatic test_reset();
        exp_t e;
        #3;
        tests_run++; if (bus_if.acc_out !== 8'h00 || bus_if.carry_flag !== 1'b0 || bus_if.zero_flag !== 1'b0 || bus_if.bus_conflict !== 1'b0) begin
            tests_failed++; $display("FAIL reset_state: acc=%h c=%b z=%b conf=%b, required 00 0 0 0", bus_if.acc_out, bus_if.carry_flag, bus_if.zero_flag, bus_if.bus_conflict); end
        @(negedge clk); rst = 1'b1;
        load(8'h5A);
        tests_run++; if (bus_if.acc_out !== 8'h5A) begin
            tests_failed++; $display("FAIL reset_load: acc=%h required 5a", bus_if.acc_out); end
        start_op(8'hA6, 1'b0, 1'b1);
        tick();
        e = exp_q.pop_front();
        idle();
        tests_run++; if (bus_if.bus_conflict !== 1'b1 || bus_if.carry_flag !== e.carry || bus_if.zero_flag !== e.zero) begin
            tests_failed++; $display("FAIL reset_preset: c=%b z=%b conf=%b, required %b %b 1", bus_if.carry_flag, bus_if.zero_flag, bus_if.bus_conflict, e.carry, e.zero); end
        #2 rst = 1'b0;
        #1;
        tests_run++; if (bus_if.acc_out !== 8'h00 || bus_if.carry_flag !== 1'b0 || bus_if.zero_flag !== 1'b0 || bus_if.bus_conflict !== 1'b0) begin
            tests_failed++; $display("FAIL reset_async: acc=%h c=%b z=%b conf=%b, required 00 0 0 0", bus_if.acc_out, bus_if.carry_flag, bus_if.zero_flag, bus_if.bus_conflict); end
        acc_m = 8'h00;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_load_enable();
        load(8'hAA);
        bus_if.enable = 1'b1;
        #1;
        tests_run++; if (bus_if.acc_out !== 8'hAA || bus_if.data_out_bus !== 8'hAA || bus_if.bus_drive !== 1'b1) begin
            tests_failed++; $display("FAIL load_enable: acc=%h out=%h drv=%b, required aa aa 1", bus_if.acc_out, bus_if.data_out_bus, bus_if.bus_drive); end
        bus_if.enable = 1'b0;
        #1;
        tests_run++; if (bus_if.data_out_bus !== 8'h00 || bus_if.bus_drive !== 1'b0 || bus_if.acc_out !== 8'hAA) begin
            tests_failed++; $display("FAIL bus_release: out=%h drv=%b acc=%h, required 00 0 aa", bus_if.data_out_bus, bus_if.bus_drive, bus_if.acc_out); end
    endtask

    task automatic test_add_carry();
        exp_t e;
        load(8'hF0);
        start_op(8'h20, 1'b0, 1'b0);
        #1;
        e = exp_q.pop_front();
        tests_run++; if (bus_if.data_out_bus !== e.res || bus_if.bus_drive !== 1'b1) begin
            tests_failed++; $display("FAIL add_result: out=%h drv=%b, required %h 1", bus_if.data_out_bus, bus_if.bus_drive, e.res); end
        bus_if.data_in_bus = bus_if.data_out_bus; bus_if.loada = 1'b1;
        tick();
        idle();
        acc_m = e.res;
        tests_run++; if (bus_if.carry_flag !== e.carry || bus_if.zero_flag !== e.zero || bus_if.acc_out !== acc_m) begin
            tests_failed++; $display("FAIL add_flags: c=%b z=%b acc=%h, required %b %b %h", bus_if.carry_flag, bus_if.zero_flag, bus_if.acc_out, e.carry, e.zero, acc_m); end
    endtask

    task automatic test_sub_zero();
        exp_t e;
        load(8'hCC);
        start_op(8'hCC, 1'b1, 1'b0);
        #1;
        e = exp_q.pop_front();
        tests_run++; if (bus_if.data_out_bus !== e.res) begin
            tests_failed++; $display("FAIL subz_result: out=%h required %h", bus_if.data_out_bus, e.res); end
        tick();
        idle();
        tests_run++; if (bus_if.carry_flag !== e.carry || bus_if.zero_flag !== e.zero) begin
            tests_failed++; $display("FAIL subz_flags: c=%b z=%b, required %b %b", bus_if.carry_flag, bus_if.zero_flag, e.carry, e.zero); end
        load(8'h01);
        tests_run++; if (bus_if.carry_flag !== e.carry || bus_if.zero_flag !== e.zero || bus_if.acc_out !== 8'h01) begin
            tests_failed++; $display("FAIL subz_hold: c=%b z=%b acc=%h, required %b %b 01", bus_if.carry_flag, bus_if.zero_flag, bus_if.acc_out, e.carry, e.zero); end
    endtask

    task automatic test_sub_borrow();
        exp_t e;
        load(8'h05);
        start_op(8'h07, 1'b1, 1'b0);
        #1;
        e = exp_q.pop_front();
        tests_run++; if (bus_if.data_out_bus !== e.res) begin
            tests_failed++; $display("FAIL subb_result: out=%h required %h", bus_if.data_out_bus, e.res); end
        bus_if.data_in_bus = bus_if.data_out_bus; bus_if.loada = 1'b1;
        tick();
        idle();
        acc_m = e.res;
        tests_run++; if (bus_if.carry_flag !== e.carry || bus_if.zero_flag !== e.zero || bus_if.acc_out !== acc_m) begin
            tests_failed++; $display("FAIL subb_flags: c=%b z=%b acc=%h, required %b %b %h", bus_if.carry_flag, bus_if.zero_flag, bus_if.acc_out, e.carry, e.zero, acc_m); end
        for (int i = 0; i < 3; i++) begin
            load(8'h33);
            tests_run++; if (bus_if.carry_flag !== e.carry || bus_if.zero_flag !== e.zero || bus_if.acc_out !== 8'h33) begin
                tests_failed++; $display("FAIL subb_hold%0d: c=%b z=%b acc=%h, required %b %b 33", i, bus_if.carry_flag, bus_if.zero_flag, bus_if.acc_out, e.carry, e.zero); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [W-1:0] b;
        logic s;
        for (int i = 0; i < 10; i++) begin
            b = W'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            if (i == 0) b = acc_m;
            start_op(b, s, 1'b0);
            #1;
            e = exp_q.pop_front();
            tests_run++; if (bus_if.data_out_bus !== e.res) begin
                tests_failed++; $display("FAIL b2b_result%0d: out=%h required %h", i, bus_if.data_out_bus, e.res); end
            bus_if.data_in_bus = bus_if.data_out_bus; bus_if.loada = 1'b1;
            tick();
            acc_m = e.res;
            tests_run++; if (bus_if.carry_flag !== e.carry || bus_if.zero_flag !== e.zero || bus_if.acc_out !== acc_m || bus_if.bus_conflict !== 1'b0) begin
                tests_failed++; $display("FAIL b2b_state%0d: c=%b z=%b acc=%h conf=%b, required %b %b %h 0", i, bus_if.carry_flag, bus_if.zero_flag, bus_if.acc_out, bus_if.bus_conflict, e.carry, e.zero, acc_m); end
        end
        idle();
    endtask

    task automatic test_conflict();
        exp_t e;
        load(8'h33);
        start_op(8'h11, 1'b0, 1'b1);
        #1;
        e = exp_q.pop_front();
        tests_run++; if (bus_if.data_out_bus !== e.res || bus_if.bus_drive !== 1'b1 || bus_if.bus_conflict !== 1'b0) begin
            tests_failed++; $display("FAIL conflict_bus: out=%h drv=%b conf=%b, required %h 1 0", bus_if.data_out_bus, bus_if.bus_drive, bus_if.bus_conflict, e.res); end
        tick();
        idle();
        tests_run++; if (bus_if.bus_conflict !== 1'b1 || bus_if.carry_flag !== e.carry || bus_if.zero_flag !== e.zero) begin
            tests_failed++; $display("FAIL conflict_set: conf=%b c=%b z=%b, required 1 %b %b", bus_if.bus_conflict, bus_if.carry_flag, bus_if.zero_flag, e.carry, e.zero); end
        tick(); tick();
        tests_run++; if (bus_if.bus_conflict !== 1'b1) begin
            tests_failed++; $display("FAIL conflict_sticky: conf=%b required 1", bus_if.bus_conflict); end
        rst = 1'b0;
        #1;
        tests_run++; if (bus_if.bus_conflict !== 1'b0) begin
            tests_failed++; $display("FAIL conflict_clear: conf=%b required 0", bus_if.bus_conflict); end
        @(negedge clk); rst = 1'b1;
        acc_m = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        acc_m = 8'h00;
        idle();
        test_reset();
        test_load_enable();
        test_add_carry();
        test_sub_zero();
        test_sub_borrow();
        test_back_to_back();
        test_conflict();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
